fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that sits directly upstream of `insn_mem`. It owns the program counter, drives `pc_out` into the instruction memory, and tracks the one-cycle read latency. It delivers each returned instruction with its PC to the decode stage over a valid/ready handshake, with branch/jump redirect and a one-entry skid buffer so decode back-pressure never drops a word.

## Interface
- `PC_WIDTH`, 10, width of the byte-address PC (matches `insn_mem` `pc_out`)
- `INSN_WIDTH`, 32, instruction width
- `RESET_PC`, 0, PC presented after reset
- `PC_STEP`, 4, sequential PC increment in bytes

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `pc_out`  out  PC_WIDTH  fetch address to `insn_mem`
- `insn_in`  in  INSN_WIDTH  `insn_out` of `insn_mem`
- `redirect_valid`  in  1  taken branch/jump from execute
- `redirect_pc`  in  PC_WIDTH  redirect target
- `id_valid`  out  1  `id_insn`/`id_pc` hold a valid instruction
- `id_ready`  in  1  decode accepts the instruction this cycle
- `id_insn`  out  INSN_WIDTH  fetched instruction
- `id_pc`  out  PC_WIDTH  address of `id_insn`

## Operation
- Memory model: `insn_mem` samples `pc_out` on a rising edge and presents the word on `insn_in` for the whole following cycle, giving one-cycle latency.
- Internal state:
  - `pc_out` register.
  - `pend` flag plus `pend_pc`, which mark that `insn_in` this cycle belongs to a real request.
  - Skid entry: `skid_valid`, `skid_insn`, `skid_pc`.
  - Output register: `id_valid`, `id_insn`, `id_pc`.
- Output free: `out_free = !id_valid || id_ready`.
- Issue rule: `issue = !skid_valid && !(pend && !out_free)`.
  - When `issue` is high, the edge sets `pend<=1`, `pend_pc<=pc_out`, `pc_out<=pc_out+PC_STEP`.
  - When `issue` is low, the edge sets `pend<=0` and `pc_out` holds. The memory still reads, but the word is discarded.
- Output register load priority when `out_free`:
  1. The skid entry, if valid; it becomes empty.
  2. Otherwise `{insn_in, pend_pc}` if `pend`.
  3. Otherwise `id_valid<=0`.
- Skid capture: when `pend && !out_free`, the returning word goes to the skid entry. The issue rule guarantees the skid is empty at that point, so it can never overflow.
- Simultaneous skid drain and response: if `out_free`, `skid_valid`, and `pend` are all high, the skid moves to the output and `insn_in` moves into the skid.
- Redirect (highest priority, overrides everything above):
  - `pc_out<=redirect_pc & ~3`.
  - `pend<=0`, `skid_valid<=0`, `id_valid<=0`, which squashes every in-flight and buffered word.
  - An instruction on the output that decode accepts in the same cycle as a redirect still counts as accepted.
- Arithmetic: PC increment is modulo 2^PC_WIDTH, so `pc_out` 1020 steps to 0 with no flag. `redirect_pc[1:0]` is ignored.
- `id_insn`/`id_pc` hold their value while `id_valid && !id_ready`.

## Timing
- Reset (asynchronous assert, synchronous release): `pc_out=RESET_PC`, `pend=0`, `skid_valid=0`, `id_valid=0`, `id_insn=0`, `id_pc=0`.
- First fetch:
  - First edge after release: issues `RESET_PC`.
  - Second edge: loads it to the output, so `id_valid` is high from the second cycle after release.
- Throughput: one instruction per cycle while `id_ready=1`.
- Redirect in cycle N: target presented in N+1, `pend` in N+2, `id_valid` with the target instruction in N+3, i.e. a 2-bubble penalty.
- Back-pressure: when `id_ready` drops, at most one extra word lands in the skid. `pc_out` then freezes within one cycle.
- Release of back-pressure: the skid word is delivered first, and sequential flow resumes with no gap or duplicate.
- Reset mid-operation: all state returns to reset values immediately. In-flight words are never delivered.

## Test plan
- Reset/startup: memory word at byte address A = 0xA000_0000+A, `id_ready=1`, release `rst_n` -> `id_pc` 0,4,8,12 on consecutive cycles from cycle 2, `id_insn`=0xA000_0000,0xA000_0004,...; `id_valid` low before that.
- Back-pressure: drop `id_ready` for 3 cycles while `id_pc`=8 is valid -> `id_pc`=8 held, `pc_out` frozen. On release, the sequence continues 12,16,... with no skip or repeat; skid used exactly once.
- Redirect: assert `redirect_valid` with `redirect_pc`=0x100 while words 12 and 16 are in flight -> neither 12 nor 16 is delivered; `id_pc`=0x100 appears 3 cycles after redirect, then 0x104.
- Redirect with misalignment and skid full: `redirect_pc`=0x203 while `id_ready=0` and skid valid -> skid flushed, next delivered `id_pc`=0x200.
- Wrap-around: redirect to 0x3F8 -> delivered PCs 0x3F8, 0x3FC, 0x000, 0x004.
- Mid-run reset: assert `rst_n=0` asynchronously between edges while `id_valid=1` -> `id_valid`, `pc_out`, `id_insn`, `id_pc` all read 0 before the next edge; restart matches the startup scenario.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and tracks the one-cycle insn_mem latency.
// Delivers {insn, pc} to decode through a valid/ready output register backed by a one-entry skid buffer.
module fetch_unit #(
  parameter int                   PC_WIDTH   = 10,
  parameter int                   INSN_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0]  PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [PC_WIDTH-1:0]   pc_out,
  input  logic [INSN_WIDTH-1:0] insn_in,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [INSN_WIDTH-1:0] id_insn,
  output logic [PC_WIDTH-1:0]   id_pc
);

  typedef struct packed {
    logic [INSN_WIDTH-1:0] insn;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_pend_pc;
  logic                r_pend;
  logic                r_skid_vld;
  entry_t              r_skid;
  logic                r_out_vld;
  entry_t              r_out;

  logic                w_out_free;
  logic                w_issue;
  entry_t              w_resp;

  assign w_out_free = !r_out_vld || id_ready;
  // Never launch a request whose response might have nowhere to land.
  assign w_issue    = !r_skid_vld && !(r_pend && !w_out_free);
  assign w_resp     = {insn_in, r_pend_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else if (redirect_valid) begin
      r_pc      <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      r_pend    <= 1'b0;
    end else if (w_issue) begin
      r_pend    <= 1'b1;
      r_pend_pc <= r_pc;
      r_pc      <= r_pc + PC_STEP;
    end else begin
      r_pend    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_vld <= 1'b0;
      r_skid     <= '0;
    end else if (redirect_valid) begin
      r_skid_vld <= 1'b0;
    end else if (w_out_free) begin
      // Skid drains to the output; a concurrent response refills it.
      r_skid_vld <= r_skid_vld && r_pend;
      if (r_skid_vld && r_pend) r_skid <= w_resp;
    end else if (r_pend) begin
      r_skid_vld <= 1'b1;
      r_skid     <= w_resp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
    end else if (redirect_valid) begin
      r_out_vld <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_vld) begin
        r_out_vld <= 1'b1;
        r_out     <= r_skid;
      end else if (r_pend) begin
        r_out_vld <= 1'b1;
        r_out     <= w_resp;
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign pc_out   = r_pc;
  assign id_valid = r_out_vld;
  assign id_insn  = r_out.insn;
  assign id_pc    = r_out.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural insn_mem plus an expected-PC scoreboard queue.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  pc_out;
  logic [31:0] insn_in;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_insn;
  logic [9:0]  id_pc;

  int          checks;
  int          failures;
  logic [9:0]  exp_q[$];
  logic [9:0]  e;

  fetch_unit #(.PC_WIDTH(10), .INSN_WIDTH(32), .RESET_PC(10'd0), .PC_STEP(10'd4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .insn_in(insn_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_insn(id_insn), .id_pc(id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // insn_mem: word at byte address A is 0xA000_0000 + A, one-cycle latency
  always @(posedge clk) insn_in <= 32'hA000_0000 + {22'd0, pc_out};

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    checks++; if (pc_out !== 10'd0) begin failures++; $display("FAIL reset_pc_out got=%0h exp=0", pc_out); end
    checks++; if (id_insn !== 32'd0) begin failures++; $display("FAIL reset_id_insn got=%0h exp=0", id_insn); end
    checks++; if (id_pc !== 10'd0) begin failures++; $display("FAIL reset_id_pc got=%0h exp=0", id_pc); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL cycle1_id_valid got=%0b exp=0", id_valid); end
    checks++; if (pc_out !== 10'd4) begin failures++; $display("FAIL cycle1_pc_out got=%0h exp=4", pc_out); end
  endtask

  // Cycles 2 and 3 after release: back-to-back delivery of PCs 0 and 4.
  task automatic test_startup(input string tag);
    exp_q.push_back(10'd0); exp_q.push_back(10'd4);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 id_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b1) begin
        failures++; $display("FAIL %s_valid cycle=%0d got=%0b exp=1", tag, i + 2, id_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (id_pc !== e || id_insn !== 32'hA000_0000 + {22'd0, e}) begin
          failures++; $display("FAIL %s_data got pc=%0h insn=%0h exp pc=%0h", tag, id_pc, id_insn, e);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 id_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 10'd8) begin
        failures++; $display("FAIL bp_hold got valid=%0b pc=%0h exp valid=1 pc=8", id_valid, id_pc);
      end
      checks++;
      if (pc_out !== 10'd16) begin failures++; $display("FAIL bp_pc_frozen got=%0h exp=10", pc_out); end
    end
    for (int p = 8; p <= 24; p += 4) exp_q.push_back(10'(p));
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1 id_ready = 1'b1;
      @(negedge clk);
      if (id_valid && id_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (id_pc !== e || id_insn !== 32'hA000_0000 + {22'd0, e}) begin
          failures++; $display("FAIL bp_resume got pc=%0h insn=%0h exp pc=%0h", id_pc, id_insn, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_timeout left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_midrun_reset();
    @(posedge clk); #1;
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre_valid got=%0b exp=1", id_valid); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || pc_out !== 10'd0 || id_insn !== 32'd0 || id_pc !== 10'd0) begin
      failures++;
      $display("FAIL mrst_clear got valid=%0b pc_out=%0h insn=%0h pc=%0h exp all 0", id_valid, pc_out, id_insn, id_pc);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL mrst_cycle1_valid got=%0b exp=0", id_valid); end
    test_startup("mrst_restart");
  endtask

  // Redirect in cycle 4: PC 8 is accepted that cycle, 12 and 16 are squashed.
  task automatic test_redirect();
    int seen;
    seen = 0;
    exp_q.push_back(10'd8); exp_q.push_back(10'h100); exp_q.push_back(10'h104); exp_q.push_back(10'h108);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
      redirect_valid = (i == 0); redirect_pc = 10'h100; id_ready = 1'b1;
      @(negedge clk);
      if (i == 1 || i == 2) begin
        checks++;
        if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble i=%0d got=%0b exp=0", i, id_valid); end
      end
      if (id_valid && id_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (id_pc !== e || id_insn !== 32'hA000_0000 + {22'd0, e}) begin
          failures++; $display("FAIL redir_data got pc=%0h insn=%0h exp pc=%0h", id_pc, id_insn, e);
        end
        if (e == 10'h100) begin
          seen = 1;
          checks++;
          if (i != 3) begin failures++; $display("FAIL redir_latency got=%0d exp=3", i); end
        end
      end
    end
    redirect_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || seen != 1) begin failures++; $display("FAIL redir_timeout left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  // Stall with ready low so the skid fills, then redirect to a misaligned target.
  task automatic test_redirect_skid();
    repeat (2) begin
      @(posedge clk); #1 id_ready = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 10'h203; id_ready = 1'b0;
    exp_q.push_back(10'h200); exp_q.push_back(10'h204);
    @(negedge clk);
    @(posedge clk); #1 redirect_valid = 1'b0; id_ready = 1'b1;
    checks++; if (pc_out !== 10'h200) begin failures++; $display("FAIL skid_redir_pc got=%0h exp=200", pc_out); end
    @(negedge clk);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      if (i > 0) begin @(posedge clk); #1 id_ready = 1'b1; @(negedge clk); end
      if (id_valid && id_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (id_pc !== e || id_insn !== 32'hA000_0000 + {22'd0, e}) begin
          failures++; $display("FAIL skid_redir_data got pc=%0h insn=%0h exp pc=%0h", id_pc, id_insn, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL skid_redir_timeout left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 10'h3F8; id_ready = 1'b0;
    exp_q.push_back(10'h3F8); exp_q.push_back(10'h3FC); exp_q.push_back(10'h000); exp_q.push_back(10'h004);
    @(negedge clk);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1 redirect_valid = 1'b0; id_ready = 1'b1;
      @(negedge clk);
      if (id_valid && id_ready) begin
        e = exp_q.pop_front();
        checks++;
        if (id_pc !== e || id_insn !== 32'hA000_0000 + {22'd0, e}) begin
          failures++; $display("FAIL wrap_data got pc=%0h insn=%0h exp pc=%0h", id_pc, id_insn, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_timeout left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_startup("startup");
    test_backpressure();
    test_midrun_reset();
    test_redirect();
    test_redirect_skid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
